// File: rtl/sync_monitor_if.sv
// Bundle of the sync monitor's control inputs and status outputs.
// The master modport drives configuration and the sync pulse; the slave modport is the monitor.
interface sync_monitor_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             master_sync;
    logic [CNT_W-1:0] cnt_max;
    logic [15:0]      tolerance;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] period_meas;
    logic             sync_tick;
    logic             locked;
    logic             sync_lost;
    logic             sync_err;
    logic [7:0]       miss_count;
    logic             interrupt_sig;

    modport master (
        output enable, master_sync, cnt_max, tolerance,
        input  phase_cnt, period_meas, sync_tick, locked, sync_lost,
               sync_err, miss_count, interrupt_sig
    );

    modport slave (
        input  enable, master_sync, cnt_max, tolerance,
        output phase_cnt, period_meas, sync_tick, locked, sync_lost,
               sync_err, miss_count, interrupt_sig
    );
endinterface

// File: rtl/sync_monitor.sv
// Sync pulse monitor: edge detection, period measurement, tolerance window, flywheel and lock FSM.
// Define SYNC_MON_SYNC2FF_EN to put a 2-flop synchronizer in front of edge detection.
module sync_monitor #(
    parameter int CNT_W      = 32,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic           clock_sync,
    input  logic           reset_n,
    sync_monitor_if.slave  bus
);
    localparam int W1 = CNT_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCKED, ST_LOST} state_t;

    state_t           state_q, state_d;
    logic             s, s_dly_q;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       miss_q, miss_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       fault_q, fault_d;
    logic             armed_q, armed_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             irq_q, irq_d;

`ifdef SYNC_MON_SYNC2FF_EN
    logic meta_q, sync_q;

    always_ff @(posedge clock_sync or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= bus.master_sync;
            sync_q <= meta_q;
        end
    end

    assign s = sync_q;
`else
    assign s = bus.master_sync;
`endif

    // Window bounds are one bit wider than the counters so cnt_max + tolerance cannot wrap.
    logic [W1-1:0] p_inc, hi, lo, tol_x, cmax_x;
    logic          edge_det, active, in_win;
    logic          ev_edge, ev_eval, ev_good, ev_early, ev_miss, fault;

    assign tol_x    = W1'(bus.tolerance);
    assign cmax_x   = {1'b0, bus.cnt_max};
    assign hi       = cmax_x + tol_x;
    assign lo       = (cmax_x > tol_x) ? (cmax_x - tol_x) : W1'(1);
    assign p_inc    = {1'b0, p_q} + W1'(1);
    assign in_win   = (p_inc >= lo) && (p_inc <= hi);

    assign edge_det = s & ~s_dly_q;
    assign active   = bus.enable && (state_q != ST_IDLE);
    assign ev_edge  = active && edge_det;
    // The first edge after enable or after LOST only arms measurement; it is never judged.
    assign ev_eval  = ev_edge && armed_q && (state_q != ST_LOST);
    assign ev_good  = ev_eval && in_win;
    assign ev_early = ev_eval && !in_win;
    assign ev_miss  = active && armed_q && !edge_det && (p_inc >= hi);
    assign fault    = ev_early || ev_miss;

    always_ff @(posedge clock_sync or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_ACQ;
                ST_ACQ:    if (ev_good && (good_q == 8'(LOCK_COUNT - 1))) state_d = ST_LOCKED;
                ST_LOCKED: if (fault && (fault_q == 8'(MISS_LIMIT - 1))) state_d = ST_LOST;
                ST_LOST:   if (ev_edge) state_d = ST_ACQ;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d   = ev_edge && !ev_early;
        err_d    = fault;
        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
        irq_d    = (state_d != state_q) && ((state_d == ST_LOCKED) || (state_d == ST_LOST));
    end

    always_comb begin
        p_d      = p_q;
        armed_d  = armed_q;
        good_d   = good_q;
        fault_d  = fault_q;
        period_d = period_q;
        miss_d   = miss_q;
        if (!active) begin
            p_d     = '0;
            armed_d = 1'b0;
            good_d  = '0;
            fault_d = '0;
        end else begin
            // An edge beats a coincident miss threshold: it resets phase and is judged in-window.
            if (edge_det) begin
                p_d     = '0;
                armed_d = 1'b1;
                if (armed_q) period_d = p_inc[CNT_W-1:0];
            end else if (ev_miss) begin
                p_d    = CNT_W'(bus.tolerance);
                miss_d = (miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
            end else if (armed_q) begin
                p_d = p_q + CNT_W'(1);
            end

            case (state_q)
                ST_ACQ: begin
                    fault_d = '0;
                    if (ev_good) good_d = good_q + 8'd1;
                    if (fault)   good_d = '0;
                end
                ST_LOCKED: begin
                    if (ev_good) fault_d = '0;
                    if (fault)   fault_d = fault_q + 8'd1;
                end
                ST_LOST: begin
                    if (edge_det) begin
                        good_d  = '0;
                        fault_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_sync or negedge reset_n) begin
        if (!reset_n) begin
            s_dly_q  <= 1'b0;
            p_q      <= '0;
            period_q <= '0;
            miss_q   <= '0;
            good_q   <= '0;
            fault_q  <= '0;
            armed_q  <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            s_dly_q  <= s;
            p_q      <= p_d;
            period_q <= period_d;
            miss_q   <= miss_d;
            good_q   <= good_d;
            fault_q  <= fault_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.phase_cnt     = p_q;
    assign bus.period_meas   = period_q;
    assign bus.sync_tick     = tick_q;
    assign bus.locked        = locked_q;
    assign bus.sync_lost     = lost_q;
    assign bus.sync_err      = err_q;
    assign bus.miss_count    = miss_q;
    assign bus.interrupt_sig = irq_q;
endmodule

// File: tb/tb_sync_monitor.sv
`timescale 1ns/1ps
module tb_sync_monitor;
`ifdef SYNC_MON_SYNC2FF_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        sn_tick, sn_err, sn_lock, sn_lost, sn_irq;
  logic [31:0] sn_p, sn_per;
  logic [7:0]  sn_miss;

  sync_monitor_if #(.CNT_W(32)) bus ();

  sync_monitor #(.CNT_W(32), .LOCK_COUNT(4), .MISS_LIMIT(3)) dut (
    .clock_sync (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse();
    bus.master_sync = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      step();
      if (i == 2) bus.master_sync = 1'b0;
      if (i == LAT) begin
        sn_tick = bus.sync_tick;
        sn_err  = bus.sync_err;
        sn_lock = bus.locked;
        sn_lost = bus.sync_lost;
        sn_irq  = bus.interrupt_sig;
        sn_p    = bus.phase_cnt;
        sn_per  = bus.period_meas;
        sn_miss = bus.miss_count;
      end
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.master_sync = 1'b0;
    bus.cnt_max     = 32'd100;
    bus.tolerance   = 16'd2;
    #2;
    chk("rst_phase", bus.phase_cnt === 32'd0);
    chk("rst_period", bus.period_meas === 32'd0);
    chk("rst_tick", bus.sync_tick === 1'b0);
    chk("rst_locked", bus.locked === 1'b0);
    chk("rst_lost", bus.sync_lost === 1'b0);
    chk("rst_err", bus.sync_err === 1'b0);
    chk("rst_miss", bus.miss_count === 8'd0);
    chk("rst_irq", bus.interrupt_sig === 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    step();
    bus.enable = 1'b1;
    step();
    step();
    chk("acq_phase_hold", bus.phase_cnt === 32'd0);

    pulse();
    chk("e1_tick", sn_tick === 1'b1);
    chk("e1_phase", sn_p === 32'd0);
    chk("e1_period", sn_per === 32'd0);
    chk("flywheel_start", bus.phase_cnt === 32'd1);
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("e2_period", sn_per === 32'd100);
    chk("e2_tick", sn_tick === 1'b1);
    chk("e2_err", sn_err === 1'b0);
    wait_cycles(100 - LAT - 1);
    pulse();
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("e4_locked", sn_lock === 1'b0);
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("e5_locked", sn_lock === 1'b1);
    chk("e5_irq", sn_irq === 1'b1);
    chk("e5_tick", sn_tick === 1'b1);
    chk("irq_one_cycle", bus.interrupt_sig === 1'b0);

    wait_cycles(90 - LAT - 1);
    pulse();
    chk("early_err", sn_err === 1'b1);
    chk("early_tick", sn_tick === 1'b0);
    chk("early_period", sn_per === 32'd90);
    chk("early_locked", sn_lock === 1'b1);
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("recover_tick", sn_tick === 1'b1);
    chk("recover_err", sn_err === 1'b0);
    chk("recover_period", sn_per === 32'd100);

    wait_cycles(102 - LAT - 1);
    pulse();
    chk("late_tick", sn_tick === 1'b1);
    chk("late_err", sn_err === 1'b0);
    chk("late_period", sn_per === 32'd102);
    chk("late_miss", sn_miss === 8'd0);

    wait_cycles(100);
    chk("pre_miss_phase", bus.phase_cnt === 32'd101);
    chk("pre_miss_err", bus.sync_err === 1'b0);
    step();
    chk("miss1_err", bus.sync_err === 1'b1);
    chk("miss1_phase", bus.phase_cnt === 32'd2);
    chk("miss1_count", bus.miss_count === 8'd1);
    chk("miss1_locked", bus.locked === 1'b1);
    chk("miss1_tick", bus.sync_tick === 1'b0);
    wait_cycles(100);
    chk("miss2_err", bus.sync_err === 1'b1);
    chk("miss2_count", bus.miss_count === 8'd2);
    chk("miss2_lost", bus.sync_lost === 1'b0);
    wait_cycles(100);
    chk("miss3_err", bus.sync_err === 1'b1);
    chk("miss3_count", bus.miss_count === 8'd3);
    chk("miss3_lost", bus.sync_lost === 1'b1);
    chk("miss3_locked", bus.locked === 1'b0);
    chk("miss3_irq", bus.interrupt_sig === 1'b1);
    chk("miss3_phase", bus.phase_cnt === 32'd2);
    step();
    chk("lost_irq_clear", bus.interrupt_sig === 1'b0);
    chk("lost_hold", bus.sync_lost === 1'b1);

    wait_cycles(50);
    pulse();
    chk("reacq_tick", sn_tick === 1'b1);
    chk("reacq_lost", sn_lost === 1'b0);
    chk("reacq_locked", sn_lock === 1'b0);
    chk("reacq_period", sn_per === 32'(53 + LAT));
    for (int k = 0; k < 3; k++) begin
      wait_cycles(100 - LAT - 1);
      pulse();
    end
    chk("reacq3_locked", sn_lock === 1'b0);
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("reacq4_locked", sn_lock === 1'b1);
    chk("reacq4_irq", sn_irq === 1'b1);

    bus.enable = 1'b0;
    step();
    chk("dis_phase", bus.phase_cnt === 32'd0);
    chk("dis_locked", bus.locked === 1'b0);
    chk("dis_period", bus.period_meas === 32'd100);
    chk("dis_miss", bus.miss_count === 8'd3);
    bus.enable = 1'b1;
    step();
    pulse();
    wait_cycles(100 - LAT - 1);
    pulse();
    chk("acq2_period", sn_per === 32'd100);
    wait_cycles(30);
    chk("acq2_phase", bus.phase_cnt === 32'd31);
    bus.enable = 1'b0;
    step();
    chk("acq_dis_phase", bus.phase_cnt === 32'd0);
    chk("acq_dis_locked", bus.locked === 1'b0);
    chk("acq_dis_period", bus.period_meas === 32'd100);

    bus.enable = 1'b1;
    step();
    pulse();
    for (int k = 0; k < 4; k++) begin
      wait_cycles(100 - LAT - 1);
      pulse();
    end
    chk("relock", sn_lock === 1'b1);
    wait_cycles(10);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_locked", bus.locked === 1'b0);
    chk("arst_period", bus.period_meas === 32'd0);
    chk("arst_miss", bus.miss_count === 8'd0);
    chk("arst_phase", bus.phase_cnt === 32'd0);
    #20;
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
